jk_to_t_reg: RTL



---
 rtl/jk_to_t_reg.sv | 124 ++++++++++++
 1 files changed

// File: rtl/jk_to_t_reg.sv
// jk_to_t_reg: T flip-flop register fed by JK commands through a 2-deep FIFO.
// Optional saturating toggle counter: define JK2T_TOGGLE_CNT_EN.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake (ready = FIFO not full)
//   cmd_j, cmd_k            JK command vectors
//   en                      allow FIFO head to be applied
//   cnt_clr                 sync clear of toggle counter
//   q, t_out                register state, last applied T mask
//   upd_valid               pulse: q/t_out updated at previous edge
//   toggle_cnt              saturating toggled-bit count (0 if not built)
module jk_to_t_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_j,
    input  logic [WIDTH-1:0] cmd_k,
    input  logic             en,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_out,
    output logic             upd_valid,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int EW = 2 * WIDTH;

    logic [EW-1:0]    mem [2];
    logic             wp;
    logic             rp;
    logic [1:0]       occ;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] hj;
    logic [WIDTH-1:0] hk;
    logic [WIDTH-1:0] t;

    assign full      = (occ == 2'd2);
    assign empty     = (occ == 2'd0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = !empty && en;

    assign hj = mem[rp][EW-1:WIDTH];
    assign hk = mem[rp][WIDTH-1:0];
    assign t  = (hj & ~q) | (hk & q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= {cmd_j, cmd_k};
                wp      <= !wp;
            end
            if (pop) begin
                rp <= !rp;
            end
            unique case (1'b1)
                push && !pop: occ <= occ + 2'd1;
                pop && !push: occ <= occ - 2'd1;
                default:      occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            t_out     <= '0;
            upd_valid <= 1'b0;
        end else begin
            upd_valid <= pop;
            if (pop) begin
                q     <= q ^ t;
                t_out <= t;
            end
        end
    end

`ifdef JK2T_TOGGLE_CNT_EN
    logic [CNT_W:0]   pc;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt;

    // One extra bit so the carry out flags saturation.
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + {{CNT_W{1'b0}}, t[i]};
        end
        sum = {1'b0, cnt} + pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

    assign toggle_cnt = cnt;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign toggle_cnt     = '0;
`endif

endmodule
